fa_bist_checker: RTL and testbench
==================================

FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 SETTLE_CYCLES, 2, cycles waited between applying a vector and sampling the DUT; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  sweep request, sampled only in IDLE.
REQ-005 a, b, c_in  output  1 each  stimulus to the external full adder under test.
REQ-006 c_out_obs, s_obs  input  1 each  observed DUT carry and sum.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse at end of sweep.
REQ-009 pass  output  1  sweep result, valid from done until the next accepted start.
REQ-010 err_count  output  4  mismatching vectors in current/last sweep, 0..8.
REQ-011 vec_idx  output  3  index of the vector being applied.

Function
REQ-012 FSM states SHALL be IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-013 IDLE: start=1 -> APPLY; vec_idx=0, err_count=0, pass=0; start=0 -> stay.
REQ-014 APPLY: one cycle; load settle counter with SETTLE_CYCLES; -> SETTLE, or -> CHECK if SETTLE_CYCLES=0.
REQ-015 SETTLE: decrement counter each cycle; -> CHECK after exactly SETTLE_CYCLES cycles.
REQ-016 CHECK: one cycle; compare {c_out_obs,s_obs} against expected {a,b,c_in} sum (2-bit add); mismatch -> err_count+1.
REQ-017 CHECK with vec_idx=7 -> DONE; otherwise vec_idx+1 -> APPLY.
REQ-018 DONE: one cycle; done=1; pass=1 iff final err_count=0 (including the last CHECK); -> IDLE.
REQ-019 {a,b,c_in} = vec_idx (a = MSB) in APPLY/SETTLE/CHECK; 0 in IDLE/DONE.
REQ-020 Each vector SHALL occupy SETTLE_CYCLES+2 cycles; done high in the cycle starting 8*(SETTLE_CYCLES+2) edges after the start-accept edge.
REQ-021 start while busy SHALL be ignored; start held high in DONE SHALL NOT be accepted until IDLE is reached.
REQ-022 err_count and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, vec_idx=0, err_count=0, pass=0, done=0, busy=0, a=b=c_in=0, settle counter=0, regardless of state.
REQ-024 Reset mid-sweep SHALL abandon the sweep; no done pulse SHALL follow reset release without a new start.

Configuration
REQ-025 FA_BIST_ERRLOG_EN defined: extra outputs first_fail_valid (1), first_fail_vec (3), first_fail_obs (2) capture vec_idx and {c_out_obs,s_obs} on the first mismatch of a sweep; cleared on accepted start and on reset.
REQ-026 FA_BIST_ERRLOG_EN undefined: those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package fa_bist_pkg SHALL hold the state enum, NUM_VECTORS=8, VEC_W=3 and ERR_W=4.
REQ-028 Sub-module fa_ref_model SHALL compute the expected {carry,sum} from {a,b,c_in}; the FSM SHALL instantiate it once.

Verification
REQ-029 Correct adder, SETTLE_CYCLES=2, start pulse -> done after 32 edges, pass=1, err_count=0.
REQ-030 DUT with s stuck at 0 -> err_count=4 (vectors 001,010,100,111), pass=0; with ERRLOG: first_fail_vec=3'b001, first_fail_obs=2'b00.
REQ-031 DUT with c_out inverted -> err_count=8, pass=0.
REQ-032 SETTLE_CYCLES=0 -> done after 16 edges; each vector held exactly 2 cycles.
REQ-033 start pulsed during SETTLE of vector 3 -> ignored, sweep timing unchanged, single done.
REQ-034 rst_n low during vector 5 CHECK -> outputs zero asynchronously; after release, no done, busy=0 until next start.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types and sizing for the full-adder BIST checker.
package fa_bist_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    localparam int ERR_W       = 4;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/fa_bist_checker_if.sv
// Stimulus/observation/status bundle between the BIST checker (master) and its environment (slave).
// FA_BIST_ERRLOG_EN adds the first-failure capture signals.
interface fa_bist_checker_if;
    import fa_bist_pkg::*;

    logic             start;
    logic             a;
    logic             b;
    logic             c_in;
    logic             c_out_obs;
    logic             s_obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] vec_idx;
`ifdef FA_BIST_ERRLOG_EN
    logic             first_fail_valid;
    logic [VEC_W-1:0] first_fail_vec;
    logic [1:0]       first_fail_obs;
`endif

    modport master (
        input  start, c_out_obs, s_obs,
        output a, b, c_in, busy, done, pass, err_count, vec_idx
`ifdef FA_BIST_ERRLOG_EN
        , output first_fail_valid, first_fail_vec, first_fail_obs
`endif
    );

    modport slave (
        output start, c_out_obs, s_obs,
        input  a, b, c_in, busy, done, pass, err_count, vec_idx
`ifdef FA_BIST_ERRLOG_EN
        , input first_fail_valid, first_fail_vec, first_fail_obs
`endif
    );

endinterface

// File: rtl/fa_ref_model.sv
// Golden full adder: expected {carry,sum} for the applied vector.
// Purely combinational, no backpressure.
module fa_ref_model (
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    output logic [1:0] exp_sum
);

    assign exp_sum = {1'b0, a} + {1'b0, b} + {1'b0, c_in};

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive 8-vector sweep of an external full adder; each vector lasts SETTLE_CYCLES+2 cycles.
// start is ignored while busy; FA_BIST_ERRLOG_EN adds first-failure capture.
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fa_bist_checker_if.master  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VECTORS - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] settle_cnt;
    logic [VEC_W-1:0] vec_idx;
    logic [ERR_W-1:0] err_count;
    logic             pass;
    logic [1:0]       exp_sum;
    logic             in_sweep;
    logic             mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = APPLY;
            APPLY:   state_nx = (SETTLE_LD == '0) ? CHECK : SETTLE;
            SETTLE:  if (settle_cnt <= CNT_W'(1)) state_nx = CHECK;
            CHECK:   state_nx = (vec_idx == LAST_VEC) ? DONE : APPLY;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stimulus is driven only while a vector is live so the adder sees 0 when idle.
    assign in_sweep                = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign {bus.a, bus.b, bus.c_in} = in_sweep ? vec_idx : '0;
    assign bus.busy                = (state != IDLE);
    assign bus.done                = (state == DONE);
    assign bus.pass                = pass;
    assign bus.err_count           = err_count;
    assign bus.vec_idx             = vec_idx;

    fa_ref_model u_ref (
        .a       (bus.a),
        .b       (bus.b),
        .c_in    (bus.c_in),
        .exp_sum (exp_sum)
    );

    assign mismatch = (state == CHECK) && ({bus.c_out_obs, bus.s_obs} != exp_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vec_idx    <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    vec_idx   <= '0;
                    err_count <= '0;
                    pass      <= 1'b0;
                end
                APPLY:  settle_cnt <= SETTLE_LD;
                SETTLE: settle_cnt <= settle_cnt - CNT_W'(1);
                CHECK: begin
                    if (mismatch) err_count <= err_count + ERR_W'(1);
                    // Verdict must include the final vector's own comparison.
                    if (vec_idx == LAST_VEC) pass <= (err_count == '0) && !mismatch;
                    else                     vec_idx <= vec_idx + VEC_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FA_BIST_ERRLOG_EN
    logic             ff_valid;
    logic [VEC_W-1:0] ff_vec;
    logic [1:0]       ff_obs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid <= 1'b0;
            ff_vec   <= '0;
            ff_obs   <= '0;
        end else if (state == IDLE && bus.start) begin
            ff_valid <= 1'b0;
            ff_vec   <= '0;
            ff_obs   <= '0;
        end else if (mismatch && !ff_valid) begin
            ff_valid <= 1'b1;
            ff_vec   <= vec_idx;
            ff_obs   <= {bus.c_out_obs, bus.s_obs};
        end
    end

    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_vec   = ff_vec;
    assign bus.first_fail_obs   = ff_obs;
`endif

endmodule

// File: tb/tb_fa_bist_checker.sv
// Drives two checkers (settle 2 and settle 0) against an emulated, optionally faulty full adder.
module tb_fa_bist_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          mode = 0;          // 0 good, 1 sum stuck 0, 2 carry inverted, 3 random xor faults
    logic [15:0] flt_bits = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    fa_bist_checker_if if2 ();
    fa_bist_checker_if if0 ();

    fa_bist_checker #(.SETTLE_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
    fa_bist_checker #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));

    function automatic logic [1:0] fa_obs(input logic [2:0] v, input int m, input logic [15:0] f);
        int s;
        logic [1:0] good;
        s = int'(v[2]) + int'(v[1]) + int'(v[0]);
        good = s[1:0];
        case (m)
            0:       return good;
            1:       return {good[1], 1'b0};
            2:       return {~good[1], good[0]};
            default: return good ^ f[int'(v) * 2 +: 2];
        endcase
    endfunction

    always_comb {if2.c_out_obs, if2.s_obs} = fa_obs({if2.a, if2.b, if2.c_in}, mode, flt_bits);
    always_comb {if0.c_out_obs, if0.s_obs} = fa_obs({if0.a, if0.b, if0.c_in}, mode, flt_bits);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic set_start(input bit sel0, input logic v);
        if (sel0) if0.start = v;
        else      if2.start = v;
    endtask

    task automatic sample(input bit sel0, output logic [2:0] stim, output logic bz, output logic dn,
                          output logic ps, output logic [3:0] ec);
        if (sel0) begin
            stim = {if0.a, if0.b, if0.c_in}; bz = if0.busy; dn = if0.done; ps = if0.pass; ec = if0.err_count;
        end else begin
            stim = {if2.a, if2.b, if2.c_in}; bz = if2.busy; dn = if2.done; ps = if2.pass; ec = if2.err_count;
        end
    endtask

    // Reference: count vectors whose observed value differs from the arithmetic sum.
    task automatic model(output int exp_err, output int ff_vec, output int ff_obs);
        exp_err = 0; ff_vec = -1; ff_obs = 0;
        for (int v = 0; v < 8; v++) begin
            int sum = (v >> 2 & 1) + (v >> 1 & 1) + (v & 1);
            int obs = int'(fa_obs(3'(v), mode, flt_bits));
            if (obs != sum) begin
                if (ff_vec < 0) begin ff_vec = v; ff_obs = obs; end
                exp_err++;
            end
        end
    endtask

    task automatic run_sweep(input bit sel0, input bit poke);
        int per, total, exp_err, ff_vec, ff_obs;
        logic [2:0] stim;
        logic bz, dn, ps;
        logic [3:0] ec;
        per = sel0 ? 2 : 4;
        total = 8 * per;
        model(exp_err, ff_vec, ff_obs);
        @(posedge clk); #1;
        set_start(sel0, 1'b1);
        @(posedge clk); #1;             // start-accept edge has just passed
        for (int k = 0; k <= total + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            sample(sel0, stim, bz, dn, ps, ec);
            if (k < total) begin
                check_val("stim", 32'(stim), 32'(k / per));
                check_val("busy", 32'(bz), 32'd1);
                check_val("done_early", 32'(dn), 32'd0);
            end else if (k == total) begin
                check_val("done", 32'(dn), 32'd1);
                check_val("busy_done", 32'(bz), 32'd1);
                check_val("stim_done", 32'(stim), 32'd0);
                check_val("err_count", 32'(ec), 32'(exp_err));
                check_val("pass", 32'(ps), 32'(exp_err == 0));
`ifdef FA_BIST_ERRLOG_EN
                if (!sel0) begin
                    check_val("ff_valid", 32'(if2.first_fail_valid), 32'(ff_vec >= 0));
                    if (ff_vec >= 0) begin
                        check_val("ff_vec", 32'(if2.first_fail_vec), 32'(ff_vec));
                        check_val("ff_obs", 32'(if2.first_fail_obs), 32'(ff_obs));
                    end
                end
`endif
            end else begin
                check_val("done_after", 32'(dn), 32'd0);
                check_val("busy_idle", 32'(bz), 32'd0);
                check_val("err_hold", 32'(ec), 32'(exp_err));
                check_val("pass_hold", 32'(ps), 32'(exp_err == 0));
            end
            set_start(sel0, (poke && k == 3 * per + 1) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"}, 32'(if2.busy), 32'd0);
        check_val({tag, "_done"}, 32'(if2.done), 32'd0);
        check_val({tag, "_pass"}, 32'(if2.pass), 32'd0);
        check_val({tag, "_err"}, 32'(if2.err_count), 32'd0);
        check_val({tag, "_vec"}, 32'(if2.vec_idx), 32'd0);
        check_val({tag, "_stim"}, 32'({if2.a, if2.b, if2.c_in}), 32'd0);
        check_val({tag, "_stim0"}, 32'({if0.a, if0.b, if0.c_in, if0.busy, if0.done}), 32'd0);
    endtask

    task automatic reset_mid_sweep();
        int n_done, n_busy;
        mode = 2;                       // errors accumulate, so the reset visibly clears err_count
        @(posedge clk); #1;
        if2.start = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        for (int k = 1; k <= 23; k++) begin @(posedge clk); #1; end
        check_val("rst_vec5_check", 32'({if2.a, if2.b, if2.c_in}), 32'd5);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_done = 0; n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            n_done += int'(if2.done);
            n_busy += int'(if2.busy);
        end
        check_val("rst_no_done", 32'(n_done), 32'd0);
        check_val("rst_no_busy", 32'(n_busy), 32'd0);
    endtask

    initial begin
        if2.start = 1'b0;
        if0.start = 1'b0;
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        mode = 0; run_sweep(1'b0, 1'b0);    // good adder, settle 2
        mode = 1; run_sweep(1'b0, 1'b0);    // sum stuck at 0
        mode = 2; run_sweep(1'b0, 1'b0);    // carry inverted
        mode = 0; run_sweep(1'b1, 1'b0);    // settle 0
        mode = 0; run_sweep(1'b0, 1'b1);    // start poked during vector 3 settle
        reset_mid_sweep();

        for (int i = 0; i < 10; i++) begin
            bit sel0;
            mode = int'($urandom_range(0, 3));
            flt_bits = 16'($urandom);
            sel0 = 1'($urandom_range(0, 1));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(posedge clk);
            run_sweep(sel0, !sel0 && ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
